// File: rtl/mems_write_arbiter.sv
// rtl/mems_write_arbiter.sv - round-robin Avalon-MM write arbiter for MEMS sample channels (option: MEMS_ARB_CHAN_REGION_EN)
module mems_write_arbiter #(
    parameter int          NUM_CH    = 4,
    parameter int          MEM_SIZE  = 4096,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     sample_valid,
    input  logic [8*NUM_CH-1:0]   sample_data,
    output logic [31:0]           address,
    output logic                  write,
    output logic [7:0]            write_data,
    input  logic                  waitrequest,
    output logic [2:0]            wr_chan,
    output logic                  wrap,
    output logic [NUM_CH-1:0]     overrun
);

    localparam int PTR_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
`ifdef MEMS_ARB_CHAN_REGION_EN
    localparam int REG_SIZE = MEM_SIZE / NUM_CH;
    localparam int RPTR_W   = (REG_SIZE > 1) ? $clog2(REG_SIZE) : 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01
    } state_t;

    state_t                state_q, state_d;

    logic [NUM_CH-1:0]     pending_q, pending_d;
    logic [8*NUM_CH-1:0]   hold_q, hold_d;
    logic [NUM_CH-1:0]     overrun_q, overrun_d;
    logic [2:0]            last_grant_q, last_grant_d;
    logic [31:0]           address_q, address_d;
    logic                  write_q, write_d;
    logic [7:0]            write_data_q, write_data_d;
    logic [2:0]            wr_chan_q, wr_chan_d;
    logic                  wrap_q, wrap_d;
`ifdef MEMS_ARB_CHAN_REGION_EN
    logic [NUM_CH-1:0][RPTR_W-1:0] ptr_q, ptr_d;
`else
    logic [PTR_W-1:0]      ptr_q, ptr_d;
`endif

    logic                  accept;
    logic                  any_pend;
    logic [2:0]            sel;
    logic [3:0]            start;
    logic [2*NUM_CH-1:0]   pend2;
    int                    pick;
    int                    s_idx;
    logic [7:0]            sel_data;
    logic [31:0]           sel_addr;
    logic                  ptr_wrap;

    // The write in flight is taken by the slave on any WRITE-state edge without stall.
    assign accept = (state_q == ST_WRITE) && !waitrequest;

    // Round-robin pick: rotate pending so last_grant+1 lands at bit 0, take the lowest set bit.
    always_comb begin
        start    = {1'b0, last_grant_q} + 4'd1;
        pend2    = {pending_q, pending_q} >> start;
        any_pend = |pending_q;
        pick     = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend2[i]) begin
                pick = i;
            end
        end
        s_idx = int'(start) + pick;
        if (s_idx >= NUM_CH) begin
            s_idx = s_idx - NUM_CH;
        end
        sel = 3'(s_idx);
    end

    // Held sample of the selected channel.
    always_comb begin
        sel_data = 8'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel == 3'(c)) begin
                sel_data = hold_q[8*c +: 8];
            end
        end
    end

`ifdef MEMS_ARB_CHAN_REGION_EN
    // Per-channel region pointers: address of the selected channel, advance the granted one.
    always_comb begin
        sel_addr = BASE_ADDR;
        ptr_d    = ptr_q;
        ptr_wrap = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel == 3'(c)) begin
                sel_addr = BASE_ADDR + 32'(c * REG_SIZE) + 32'(ptr_q[c]);
            end
            if (accept && (wr_chan_q == 3'(c))) begin
                if (ptr_q[c] == RPTR_W'(REG_SIZE - 1)) begin
                    ptr_d[c] = '0;
                    ptr_wrap = 1'b1;
                end else begin
                    ptr_d[c] = ptr_q[c] + RPTR_W'(1);
                end
            end
        end
    end
`else
    // Single shared pointer: samples land interleaved in grant order.
    always_comb begin
        sel_addr = BASE_ADDR + 32'(ptr_q);
        ptr_d    = ptr_q;
        ptr_wrap = 1'b0;
        if (accept) begin
            if (ptr_q == PTR_W'(MEM_SIZE - 1)) begin
                ptr_d    = '0;
                ptr_wrap = 1'b1;
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end
    end
`endif

    // Holding registers: a slot is free when empty or being drained this edge; otherwise the new sample is dropped.
    always_comb begin
        pending_d = pending_q;
        hold_d    = hold_q;
        overrun_d = overrun_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (accept && (wr_chan_q == 3'(c))) begin
                pending_d[c] = 1'b0;
            end
            if (sample_valid[c]) begin
                if (!pending_q[c] || (accept && (wr_chan_q == 3'(c)))) begin
                    hold_d[8*c +: 8] = sample_data[8*c +: 8];
                    pending_d[c]     = 1'b1;
                end else begin
                    overrun_d[c] = 1'b1;
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_pend) state_d = ST_WRITE;
            ST_WRITE: if (!waitrequest) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bus outputs: launched on leaving IDLE, frozen through stalls, write dropped on acceptance.
    always_comb begin
        address_d    = address_q;
        write_d      = write_q;
        write_data_d = write_data_q;
        wr_chan_d    = wr_chan_q;
        last_grant_d = last_grant_q;
        wrap_d       = accept && ptr_wrap;
        case (state_q)
            ST_IDLE: begin
                if (any_pend) begin
                    write_d      = 1'b1;
                    address_d    = sel_addr;
                    write_data_d = sel_data;
                    wr_chan_d    = sel;
                end
            end
            ST_WRITE: begin
                if (!waitrequest) begin
                    write_d      = 1'b0;
                    last_grant_d = wr_chan_q;
                end
            end
            default: write_d = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; reset drops write immediately, losing any in-flight sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q    <= '0;
            hold_q       <= '0;
            overrun_q    <= '0;
            last_grant_q <= 3'(NUM_CH - 1);
            address_q    <= BASE_ADDR;
            write_q      <= 1'b0;
            write_data_q <= 8'd0;
            wr_chan_q    <= 3'd0;
            wrap_q       <= 1'b0;
            ptr_q        <= '0;
        end else begin
            pending_q    <= pending_d;
            hold_q       <= hold_d;
            overrun_q    <= overrun_d;
            last_grant_q <= last_grant_d;
            address_q    <= address_d;
            write_q      <= write_d;
            write_data_q <= write_data_d;
            wr_chan_q    <= wr_chan_d;
            wrap_q       <= wrap_d;
            ptr_q        <= ptr_d;
        end
    end

    assign address    = address_q;
    assign write      = write_q;
    assign write_data = write_data_q;
    assign wr_chan    = wr_chan_q;
    assign wrap       = wrap_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_mems_write_arbiter.sv
// tb/tb_mems_write_arbiter.sv - directed table-driven bench for mems_write_arbiter (default build)
module tb_mems_write_arbiter;

    localparam int          NUM_CH    = 4;
    localparam int          MEM_SIZE  = 8;
    localparam logic [31:0] BASE_ADDR = 32'd16;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  sample_valid;
    logic [31:0] sample_data;
    logic [31:0] address;
    logic        write;
    logic [7:0]  write_data;
    logic        waitrequest;
    logic [2:0]  wr_chan;
    logic        wrap;
    logic [3:0]  overrun;

    int checks = 0;
    int passed = 0;

    typedef struct {
        int          chan;
        logic [7:0]  data;
        int          stall;
        logic [31:0] exp_addr;
        logic        exp_wrap;
    } vec_t;

    vec_t        vecs [10];
    logic [7:0]  all4_data [4];
    bit          seen;
    bit          stable;
    bit          quiet;

    mems_write_arbiter #(
        .NUM_CH    (NUM_CH),
        .MEM_SIZE  (MEM_SIZE),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .address      (address),
        .write        (write),
        .write_data   (write_data),
        .waitrequest  (waitrequest),
        .wr_chan      (wr_chan),
        .wrap         (wrap),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] lane(input int ch, input logic [7:0] d);
        logic [31:0] r;
        r = 32'hE1E2E3E4;
        r[8*ch +: 8] = d;
        return r;
    endfunction

    // Called at a falling edge; returns at the falling edge after the latching rise.
    task automatic strobe(input logic [3:0] mask, input logic [31:0] data);
        sample_valid = mask;
        sample_data  = data;
        @(negedge clock);
        sample_valid = 4'd0;
    endtask

    task automatic wait_write(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (write === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic check_xfer(input string name, input logic [31:0] a, input logic [7:0] d, input logic [2:0] ch);
        check({name, "_addr"}, address, a);
        check({name, "_data"}, 32'(write_data), 32'(d));
        check({name, "_chan"}, 32'(wr_chan), 32'(ch));
    endtask

    task automatic check_quiet(input string name, input int cycles);
        quiet = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (write !== 1'b0) quiet = 1'b0;
        end
        check(name, 32'(quiet), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Single-channel transactions: {chan, data, stall, expected address, expected wrap}
        vecs[0] = '{1, 8'h5A, 5, 32'd16, 1'b0};
        vecs[1] = '{0, 8'h01, 0, 32'd17, 1'b0};
        vecs[2] = '{0, 8'h02, 0, 32'd18, 1'b0};
        vecs[3] = '{0, 8'h03, 2, 32'd19, 1'b0};
        vecs[4] = '{0, 8'h04, 0, 32'd20, 1'b0};
        vecs[5] = '{0, 8'h05, 1, 32'd21, 1'b0};
        vecs[6] = '{0, 8'h06, 0, 32'd22, 1'b0};
        vecs[7] = '{0, 8'h07, 0, 32'd23, 1'b1};
        vecs[8] = '{0, 8'h08, 0, 32'd16, 1'b0};
        vecs[9] = '{0, 8'h09, 3, 32'd17, 1'b0};
        all4_data[0] = 8'h11;
        all4_data[1] = 8'h22;
        all4_data[2] = 8'h33;
        all4_data[3] = 8'h44;

        reset        = 1'b1;
        sample_valid = 4'd0;
        sample_data  = 32'd0;
        waitrequest  = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_address", address, 32'd16);
        check("rst_write", 32'(write), 32'd0);
        check("rst_write_data", 32'(write_data), 32'd0);
        check("rst_wr_chan", 32'(wr_chan), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // All four channels strobe together: served 0..3 in order, one write-high cycle each.
        strobe(4'hF, 32'h44332211);
        for (int k = 0; k < 4; k++) begin
            wait_write("all4_seen", seen);
            if (seen) begin
                check_xfer("all4", BASE_ADDR + 32'(k), all4_data[k], 3'(k));
                @(negedge clock);
                check("all4_write_pulse", 32'(write), 32'd0);
            end
        end

        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Table: stalls, pointer advance and wrap at MEM_SIZE=8.
        for (int v = 0; v < 10; v++) begin
            waitrequest = (vecs[v].stall > 0);
            strobe(4'(1 << vecs[v].chan), lane(vecs[v].chan, vecs[v].data));
            wait_write($sformatf("vec%0d_seen", v), seen);
            if (seen) begin
                check_xfer($sformatf("vec%0d", v), vecs[v].exp_addr, vecs[v].data, 3'(vecs[v].chan));
                if (vecs[v].stall > 0) begin
                    stable = 1'b1;
                    for (int s = 0; s < vecs[v].stall; s++) begin
                        @(negedge clock);
                        if (write !== 1'b1 || address !== vecs[v].exp_addr ||
                            write_data !== vecs[v].data || wr_chan !== 3'(vecs[v].chan))
                            stable = 1'b0;
                    end
                    check($sformatf("vec%0d_stable", v), 32'(stable), 32'd1);
                end
                waitrequest = 1'b0;
                @(negedge clock);
                check($sformatf("vec%0d_write_low", v), 32'(write), 32'd0);
                check($sformatf("vec%0d_wrap", v), 32'(wrap), 32'(vecs[v].exp_wrap));
                @(negedge clock);
                check($sformatf("vec%0d_wrap_after", v), 32'(wrap), 32'd0);
            end
            waitrequest = 1'b0;
        end

        // Overrun: second strobe on channel 2 while its write is stalled is dropped.
        waitrequest = 1'b1;
        strobe(4'b0100, lane(2, 8'hAA));
        wait_write("ovr_seen", seen);
        check_xfer("ovr", 32'd18, 8'hAA, 3'd2);
        strobe(4'b0100, lane(2, 8'hBB));
        check("ovr_flag", 32'(overrun), 32'h4);
        check("ovr_held_data", 32'(write_data), 32'hAA);
        check("ovr_still_write", 32'(write), 32'd1);
        waitrequest = 1'b0;
        @(negedge clock);
        check("ovr_write_low", 32'(write), 32'd0);
        check_quiet("ovr_dropped", 5);
        check("ovr_sticky", 32'(overrun), 32'h4);

        // Same-edge completion and new sample on channel 1: latched, no overrun.
        waitrequest = 1'b1;
        strobe(4'b0010, lane(1, 8'h31));
        wait_write("same_seen1", seen);
        check_xfer("same1", 32'd19, 8'h31, 3'd1);
        waitrequest = 1'b0;
        strobe(4'b0010, lane(1, 8'h32));
        check("same_write_low", 32'(write), 32'd0);
        check("same_no_overrun", 32'(overrun), 32'h4);
        wait_write("same_seen2", seen);
        check_xfer("same2", 32'd20, 8'h32, 3'd1);
        @(negedge clock);
        check("same2_write_low", 32'(write), 32'd0);

        // Asynchronous reset during a stalled write.
        waitrequest = 1'b1;
        strobe(4'b1000, lane(3, 8'h99));
        wait_write("rstx_seen", seen);
        check_xfer("rstx", 32'd21, 8'h99, 3'd3);
        #1;
        reset = 1'b1;
        #1;
        check("rstx_write", 32'(write), 32'd0);
        check("rstx_address", address, 32'd16);
        check("rstx_write_data", 32'(write_data), 32'd0);
        check("rstx_wr_chan", 32'(wr_chan), 32'd0);
        check("rstx_wrap", 32'(wrap), 32'd0);
        check("rstx_overrun", 32'(overrun), 32'd0);
        @(negedge clock);
        reset       = 1'b0;
        waitrequest = 1'b0;
        check_quiet("rstx_lost", 4);
        strobe(4'b0100, lane(2, 8'h66));
        wait_write("rstx_next_seen", seen);
        check_xfer("rstx_next", 32'd16, 8'h66, 3'd2);
        @(negedge clock);
        check("rstx_next_low", 32'(write), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
